bin_to_bcd: RTL and testbench
=============================

# bin_to_bcd

Clocked 16-bit unsigned binary to 5-digit packed-BCD converter. It uses an iterative shift-add-3 (double-dabble) engine and runs continuously on the system clock: it samples the input, converts it over 16 shift cycles, publishes the result, then repeats. It sits between binary datapaths and decimal display drivers, such as 7-segment scanners. Its output register changes only when a conversion completes, so downstream logic never sees partial results.

## Interface
- No parameters; widths are fixed at 16-bit input and 20-bit output.
- Sys_CLK  input  1  system clock (50 MHz nominal); all state changes on rising edge.
- Sys_RST  input  1  reset; synchronous and active-high.
- Data_Bin  input  16  unsigned binary value, 0..65535; level input with no handshake; may change at any time.
- Data_BCD  output  20  packed BCD, registered.
  - [19:16] ten-thousands
  - [15:12] thousands
  - [11:8] hundreds
  - [7:4] tens
  - [3:0] units

## Operation
- State machine with 3 states: LOAD, SHIFT, UPDATE.
- LOAD (1 cycle):
  - bin_sr <= Data_Bin; bcd_sr (20 bits) <= 0; cnt <= 0.
  - Next state: SHIFT.
- SHIFT (exactly 16 cycles, cnt 0..15). Each cycle:
  - Every BCD nibble of bcd_sr that is ≥5 gets +3. All 5 nibbles are tested in parallel on the pre-shift value.
  - {bcd_sr, bin_sr} <= {adjusted_bcd_sr, bin_sr} << 1, so the MSB of bin_sr enters bcd_sr[0].
  - cnt increments; after the cycle with cnt==15, next state is UPDATE.
- UPDATE (1 cycle):
  - Data_BCD <= bcd_sr.
  - Next state: LOAD.
- Conversion loop is free-running and needs no start signal.
- Arithmetic rules:
  - The add-3 is 4-bit per nibble. Because the adjust is applied only to nibbles ≥5, a nibble never exceeds 9 after the shift.
  - The top nibble never exceeds 6 for 16-bit input; the adjust logic is still applied uniformly.
- Data_Bin is sampled only in LOAD. Changes during SHIFT/UPDATE affect only the next conversion.
- Data_BCD holds its value in all states except UPDATE. It always holds a complete, valid BCD result or the reset value.
- Reset (Sys_RST high at a rising edge), including mid-conversion:
  - Data_BCD <= 0, state <= LOAD, cnt <= 0, bin_sr <= 0, bcd_sr <= 0.
  - Any in-progress conversion is discarded.
  - While reset is held, nothing advances.

## Timing
- Conversion period: 18 cycles (1 LOAD + 16 SHIFT + 1 UPDATE), repeating back-to-back.
- Relative to the LOAD edge that samples Data_Bin (edge N):
  - Data_BCD reflects that sample after edge N+17.
  - The next sample is taken at edge N+18.
- After reset deasserts, the first LOAD executes on the first rising edge with Sys_RST low. The first valid result appears 17 edges later.
- Worst-case latency from a Data_Bin change to the matching Data_BCD is 35 cycles (700 ns at 50 MHz). The input must be held stable at least 18 cycles to be guaranteed sampled.
- Data_BCD changes at most once per 18 cycles. If the input is unchanged, it re-writes the same value, with no glitch and no intermediate value.

## Test plan
- Reset: assert Sys_RST for 3 cycles with Data_Bin=16'd1234 -> Data_BCD=20'h00000 throughout reset. After release, Data_BCD=20'h01234 after the 18th edge and unchanged thereafter.
- Sweep values, holding each ≥40 cycles:
  - 0 -> 20'h00000
  - 128 (16'h0080) -> 20'h00128
  - 9 -> 20'h00009
  - 10 -> 20'h00010
  - 9999 -> 20'h09999
  - 10000 -> 20'h10000
  - 65535 -> 20'h65535
- Latency: change Data_Bin exactly one cycle before a LOAD edge, from 0 to 128 -> Data_BCD becomes 20'h00128 exactly 17 edges after that LOAD edge. Change it one cycle after a LOAD edge -> the update lands 34 cycles after the change.
- Mid-conversion input change: toggle Data_Bin between 500 and 777 during SHIFT -> Data_BCD only ever shows 20'h00500 or 20'h00777, never a mix. Sample Data_BCD every cycle and check all nibbles ≤9.
- Reset mid-conversion: assert Sys_RST for 1 cycle at SHIFT cnt=7 with Data_Bin=4321 -> Data_BCD=0 on the next edge. After release, 20'h04321 appears 18 edges after the release edge.
- Exhaustive: step Data_Bin through all 65536 values, 20 cycles each -> every published Data_BCD equals the decimal of the sampled value.

Source files
------------

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: free-running 16-bit binary to 5-digit packed-BCD converter.
// Double-dabble engine: one LOAD cycle, 16 SHIFT cycles, one UPDATE cycle, repeating.
// Data_BCD is written only in UPDATE, so it never exposes a partial conversion.
module bin_to_bcd (
  input  logic        Sys_CLK,
  input  logic        Sys_RST,
  input  logic [15:0] Data_Bin,
  output logic [19:0] Data_BCD
);

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StShift  = 2'd1,
    StUpdate = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] out_q, out_d;
  logic [19:0] bcd_adj;

  // Add-3 on every nibble >= 5, evaluated in parallel on the pre-shift value.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath updates for the LOAD / SHIFT / UPDATE loop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    out_d   = out_q;
    unique case (state_q)
      StLoad: begin
        bin_d   = Data_Bin;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // {bcd, bin} shifted left as one 36-bit register; bin MSB enters bcd LSB.
        bcd_d = {bcd_adj[18:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        out_d   = bcd_q;
        state_d = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any conversion in flight.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      out_q   <= out_d;
    end
  end

  assign Data_BCD = out_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: scoreboard bench for bin_to_bcd.
// A model process tracks the 18-cycle conversion period and, at each LOAD edge, queues the
// decimal value of the sampled input together with the edge at which it must be published.
// A monitor checks Data_BCD every cycle against the most recently due expectation.
module tb_bin_to_bcd;

  logic        Sys_CLK;
  logic        Sys_RST;
  logic [15:0] Data_Bin;
  logic [19:0] Data_BCD;

  bin_to_bcd dut (
    .Sys_CLK  (Sys_CLK),
    .Sys_RST  (Sys_RST),
    .Data_Bin (Data_Bin),
    .Data_BCD (Data_BCD)
  );

  initial begin
    Sys_CLK = 1'b0;
    forever #10 Sys_CLK = ~Sys_CLK;
  end

  typedef struct {
    int unsigned due;
    logic [19:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc      = 0;
  int unsigned phase    = 0;   // 0: next edge is a LOAD edge
  bit          armed    = 1'b0;
  logic [19:0] exp_hold = '0;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Decimal digits by plain division, independent of any shift-add scheme.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: follows the period and schedules expected publications.
  always @(posedge Sys_CLK) begin
    cyc++;
    if (Sys_RST) begin
      armed = 1'b1;
      phase = 0;
      sb_q.delete();
      sb_q.push_back('{due: cyc, val: 20'h0});
    end else begin
      if (phase == 0) sb_q.push_back('{due: cyc + 17, val: to_bcd(Data_Bin)});
      phase = (phase == 17) ? 0 : phase + 1;
    end
  end

  // Monitor: retire due expectations, then compare the output once per cycle.
  always @(negedge Sys_CLK) begin
    if (armed) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_hold = sb_q[0].val;
        void'(sb_q.pop_front());
      end
      check("scoreboard", Data_BCD, exp_hold);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Sys_CLK);
  endtask

  // Advance to the negedge where the model phase equals p; bounded.
  task automatic wait_phase(input int unsigned p);
    int tries;
    tries = 0;
    do begin
      @(negedge Sys_CLK);
      tries++;
    end while (phase != p && tries < 40);
    check_int("wait_phase_bound", (phase == p) ? 1 : 0, 1);
  endtask

  // Count rising edges until Data_BCD shows v; -1 if the bound expires.
  task automatic edges_until(input logic [19:0] v, input int bound, output int edges);
    edges = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge Sys_CLK);
      if (Data_BCD === v) begin
        edges = n;
        break;
      end
    end
  endtask

  logic [15:0] sweep[7] = '{16'd0, 16'd128, 16'd9, 16'd10, 16'd9999, 16'd10000, 16'd65535};
  int          e;
  logic [15:0] rv;

  initial begin
    // Reset held for 3 cycles with a non-zero input.
    Sys_RST  = 1'b1;
    Data_Bin = 16'd1234;
    cycles(3);
    check("reset_value", Data_BCD, 20'h00000);
    Sys_RST = 1'b0;
    edges_until(20'h01234, 40, e);
    check_int("first_result_edges", e, 18);
    cycles(20);
    check("first_result_held", Data_BCD, 20'h01234);

    // Directed sweep, each value held 40 cycles.
    foreach (sweep[i]) begin
      Data_Bin = sweep[i];
      cycles(40);
      check("sweep", Data_BCD, to_bcd(sweep[i]));
    end

    // Latency: change in the cycle before a LOAD edge -> 18 edges (17 after LOAD).
    Data_Bin = 16'd0;
    cycles(40);
    wait_phase(0);
    Data_Bin = 16'd128;
    edges_until(20'h00128, 60, e);
    check_int("latency_before_load", e, 18);

    // Change in the cycle after a LOAD edge -> 35 edges (34 after edge N+1).
    Data_Bin = 16'd0;
    cycles(40);
    wait_phase(1);
    Data_Bin = 16'd128;
    edges_until(20'h00128, 60, e);
    check_int("latency_after_load", e, 35);

    // Toggle between 500 and 777 during SHIFT; only whole results may appear.
    for (int k = 0; k < 180; k++) begin
      @(negedge Sys_CLK);
      if (phase >= 2 && phase <= 15) Data_Bin = $urandom_range(0, 1) ? 16'd500 : 16'd777;
      if (k > 40) check_int("no_mix", (Data_BCD == 20'h00500 || Data_BCD == 20'h00777), 1);
    end

    // Reset pulse landing on the SHIFT cnt=7 edge.
    Data_Bin = 16'd4321;
    cycles(40);
    check("pre_reset", Data_BCD, 20'h04321);
    wait_phase(8);
    Sys_RST = 1'b1;
    @(negedge Sys_CLK);
    check("mid_reset_clears", Data_BCD, 20'h00000);
    Sys_RST = 1'b0;
    edges_until(20'h04321, 40, e);
    check_int("post_reset_edges", e, 18);

    // Randomized values with random hold times, some shorter than a period.
    for (int k = 0; k < 300; k++) begin
      rv = 16'($urandom);
      if (k % 10 == 0) rv = 16'($urandom_range(0, 20));
      Data_Bin = rv;
      cycles($urandom_range(5, 45));
    end
    cycles(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
